// File: rtl/spu_pkg.sv
// Shared types and default widths for the SPU write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spu_pkg;

    localparam int DEF_DATA_W = 17;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } spu_state_e;

endpackage

// File: rtl/spu_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted req at or above ptr (modulo N).
// Latency: winner is combinational; the pointer moves on the clock after an accepted grant.
// Backpressure: the pointer holds while advance is low or no req is pending.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Rotating priority search starting at ptr_q
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!win_vld && req[(int'(ptr_q) + i) % N]) begin
                win_vld                          = 1'b1;
                win_oh[(int'(ptr_q) + i) % N]    = 1'b1;
                win_idx                          = IDX_W'((int'(ptr_q) + i) % N);
            end
        end
    end

    // Next pointer is one past the winner, wrapping the top requester back to 0
    always_comb begin
        ptr_d = ptr_q;
        if (advance && win_vld) begin
            ptr_d = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spu_write_arbiter.sv
// Shares the i_next write port among N_SPU SPUs round-robin and sequences each timestep.
// Latency: req -> grant/mem_we one cycle (both registered together); step_done one cycle after DRAIN empties.
// Backpressure: output register holds while mem_we & ~mem_ready; no grants are issued until it frees.
module spu_write_arbiter
    import spu_pkg::*;
#(
    parameter int N_SPU     = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int QUIET_CYC = 2
) (
    input  logic                      clk,
    input  logic                      asyn_reset_n,
    input  logic                      step_start,
    input  logic                      fifo_empty,
    input  logic [N_SPU-1:0]          spu_busy,
    input  logic [N_SPU-1:0]          req,
    input  logic [N_SPU*ADDR_W-1:0]   req_addr,
    input  logic [N_SPU*DATA_W-1:0]   req_data,
    output logic [N_SPU-1:0]          grant,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    output logic                      step_done,
    output logic [1:0]                state
);

    localparam int IDX_W = (N_SPU > 1) ? $clog2(N_SPU) : 1;
    localparam int QW    = $clog2(QUIET_CYC + 1);

    spu_state_e          state_q, state_d;
    logic [QW-1:0]       quiet_q, quiet_d;
    logic [N_SPU-1:0]    grant_q, grant_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [N_SPU-1:0]    req_eff;
    logic [N_SPU-1:0]    win_oh;
    logic [IDX_W-1:0]    win_idx;
    logic                win_vld;
    logic                arb_on;
    logic                out_free;
    logic                capture;
    logic                quiet_cyc;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // A requester still sees its grant this cycle and may not have dropped req yet;
    // masking it prevents capturing the same write twice.
    assign req_eff   = req & ~grant_q;
    assign arb_on    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign out_free  = ~mem_we_q | mem_ready;
    assign capture   = arb_on & out_free & win_vld;
    assign quiet_cyc = fifo_empty & ~|spu_busy & ~|req;

    rr_arbiter #(
        .N     (N_SPU),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (asyn_reset_n),
        .req     (req_eff),
        .advance (capture),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Select the winning SPU's address and data
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_SPU; i++) begin
            if (win_oh[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-entry output register: load on capture, hold while stalled, clear valid once accepted
    always_comb begin
        grant_d     = '0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (capture) begin
            grant_d     = win_oh;
            mem_we_d    = 1'b1;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_data;
        end else if (out_free) begin
            mem_we_d    = 1'b0;
        end
    end

    // Timestep sequencing: RUN until enough quiet cycles, DRAIN the write port, pulse DONE
    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        case (state_q)
            ST_IDLE: begin
                if (step_start) begin
                    state_d = ST_RUN;
                    quiet_d = '0;
                end
            end
            ST_RUN: begin
                if (quiet_cyc) begin
                    quiet_d = quiet_q + QW'(1);
                    if (quiet_q == QW'(QUIET_CYC - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    quiet_d = '0;
                end
            end
            ST_DRAIN: begin
                if (|req) begin
                    state_d = ST_RUN;
                    quiet_d = '0;
                end else if (out_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset discards any in-flight write
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q     <= ST_IDLE;
            quiet_q     <= '0;
            grant_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            quiet_q     <= quiet_d;
            grant_q     <= grant_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign grant     = grant_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign step_done = (state_q == ST_DONE);
    assign state     = state_q;

endmodule

// File: doc/spu_write_arbiter.md
Name: spu_write_arbiter

Overview:
- Shares the single i_next memory write port among N_SPU synaptic processing units, granting one write per cycle in round-robin order.
- Sequences each simulation timestep: it opens on step_start, then detects quiescence (spike FIFO empty, all SPUs idle, no pending writes, output register drained) and pulses step_done.
- Sits between the SPU array and the i_next current memory; the neuron-update stage consumes step_done.

Parameters:
N_SPU, 4, number of requesting SPUs (>=2)
DATA_W, 17, i_next word width
ADDR_W, 8, i_next memory address width (neuron index)
QUIET_CYC, 2, consecutive quiet cycles required in RUN before DRAIN

Ports:
clk  input  1  system clock, rising edge
asyn_reset_n  input  1  asynchronous active-low reset
step_start  input  1  pulse: begin timestep; honoured only in IDLE
fifo_empty  input  1  spike FIFO empty flag
spu_busy  input  N_SPU  per-SPU busy
req  input  N_SPU  per-SPU write request (req_write_i_next)
req_addr  input  N_SPU*ADDR_W  per-SPU destination address, SPU i at bits [i*ADDR_W +: ADDR_W]
req_data  input  N_SPU*DATA_W  per-SPU i_next value, same packing
grant  output  N_SPU  one-hot, one-cycle pulse: request captured
mem_we  output  1  write valid to i_next memory
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
mem_ready  input  1  memory accepts write when mem_we & mem_ready
step_done  output  1  one-cycle pulse at end of timestep
state  output  2  FSM state (debug)

Behaviour:
- Reset (asyn_reset_n low, any time, including mid-transfer):
  - state=IDLE; grant=0; mem_we=0; mem_addr=0; mem_wdata=0; step_done=0.
  - RR pointer=0; quiet counter=0; an in-flight write is discarded.
- States: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- IDLE:
  - No grants; requests stay pending.
  - step_start=1 -> RUN; quiet counter cleared.
- RUN:
  - Arbitrates every cycle.
  - Quiet cycle = fifo_empty & ~|spu_busy & ~|req. Counter increments on a quiet cycle and clears otherwise.
  - When the counter reaches QUIET_CYC -> DRAIN.
- DRAIN:
  - Still arbitrates; a new req returns to RUN with the counter cleared.
  - When mem_we=0, or mem_we&mem_ready this cycle, and no req -> DONE.
- DONE: step_done=1 for exactly one cycle -> IDLE.
- step_start outside IDLE is ignored.
- Output register (one-entry):
  - It is free when mem_we=0 or mem_we&mem_ready.
  - If free, RUN/DRAIN and |req: pick the winner, load mem_addr/mem_wdata from the winner, set mem_we=1, and pulse grant[winner] in the same cycle (registered, visible next cycle). This gives 1 write/cycle when mem_ready stays high.
  - If not free: hold mem_we/addr/data stable and issue no grant.
  - If free and no req: mem_we drops to 0 after acceptance.
- Round-robin arbitration:
  - Search from ptr upward, modulo N_SPU; the first asserted req wins.
  - After a grant, ptr = (winner+1) mod N_SPU, wrapping N_SPU-1 -> 0.
  - ptr holds when there is no grant.
- Requester contract:
  - An SPU holds req/addr/data stable until it sees grant.
  - After grant it drops req the next cycle.
  - Arbiter latency from req to grant is >=1 cycle; the write reaches mem one cycle after capture.
- Same address from two SPUs: both writes are issued in grant order. Accumulation coherence is the SPUs' responsibility.

Decomposition:
- Shared package spu_pkg:
  - state encodings ST_IDLE..ST_DONE.
  - default widths DATA_W=17, ADDR_W=8.
- One sub-module: rr_arbiter (req, ptr -> one-hot winner + index, combinational plus pointer register), reusable for FIFO dequeue arbitration.

Test Plan:
- Reset mid-write: mem_we=1 with mem_ready=0, then asyn_reset_n=0 -> all outputs 0 asynchronously, state=0; after release no grant until step_start.
- Single requester: step_start, req=0001, addr=5, data=0x00900, mem_ready=1 -> grant=0001 next cycle; mem_we=1 with addr 5 and data 0x00900 in that cycle; mem_we=0 after.
- Round-robin wrap: req=1111 held each cycle until grant, mem_ready=1 -> grants 0001,0010,0100,1000,0001; ptr wraps 3->0.
- Back-pressure: req=0011, mem_ready=0 for 3 cycles -> first grant, then no further grant, mem_addr/data stable; mem_ready=1 -> second grant next cycle.
- Step completion, QUIET_CYC=2: fifo_empty=1, spu_busy=0, req=0 after last write accepted -> RUN 2 quiet cycles, DRAIN, DONE, step_done single pulse, IDLE.
- Late request in DRAIN: req=0100 arrives in DRAIN -> return to RUN, grant=0100, no step_done until quiet again; step_start during RUN ignored.
